// File: rtl/ex_div.sv
// ex_div: iterative 32-bit divide/remainder unit for the EX stage.
// Restoring radix-2 divider, one quotient bit per clock while in ON.
// Signed operands are divided as magnitudes and sign-corrected when the
// result is registered.
// Divide-by-zero and signed overflow return fixed results. By default they
// still run the full 32 steps so every divide has the same latency. Define
// DIV_SPECIAL_FASTPATH_EN to send these cases straight to END instead.
//
// Handshake: start_i is held high from the request cycle until the result
// has been consumed. ready_o=1 marks result_o as valid. The first edge with
// start_i=0 while in END returns the block to IDLE. annul_i drops any
// operation and blocks a new start on the same edge.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        rem_sel_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

  // state
  logic [1:0]  state_q,   state_d;
  logic [4:0]  cnt_q,     cnt_d;
  logic [64:0] rq_q,      rq_d;       // {partial remainder[32:0], dividend/quotient[31:0]}
  logic [31:0] dvsr_q,    dvsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        rem_sel_q, rem_sel_d;
  logic        spec_q,    spec_d;
  logic [31:0] spec_res_q, spec_res_d;
  logic [31:0] result_q,  result_d;
  logic        ready_q,   ready_d;

  // operand decode at the start edge
  logic        op1_neg, op2_neg;
  logic [31:0] op1_abs, op2_abs;
  logic        div_zero, sgn_ovf, is_special;
  logic [31:0] spec_val;

  // one division step and result fixup
  logic [33:0] diff;
  logic [64:0] rq_step;
  logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix, final_res;

  // Operand magnitudes and special-case detection from the live inputs.
  always_comb begin
    op1_neg    = signed_i & opdata1_i[31];
    op2_neg    = signed_i & opdata2_i[31];
    op1_abs    = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_abs    = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;
    div_zero   = (opdata2_i == 32'd0);
    sgn_ovf    = signed_i && (opdata1_i == 32'h8000_0000) && (opdata2_i == 32'hFFFF_FFFF);
    is_special = div_zero | sgn_ovf;
    if (div_zero) spec_val = rem_sel_i ? opdata1_i : 32'hFFFF_FFFF;
    else          spec_val = rem_sel_i ? 32'd0     : 32'h8000_0000;
  end

  // Restoring step: shift in the next dividend bit and subtract the divisor
  // when the trial remainder does not go negative.
  always_comb begin
    diff = rq_q[64:31] - {2'b00, dvsr_q};
    if (diff[33]) rq_step = {rq_q[63:0], 1'b0};
    else          rq_step = {diff[32:0], rq_q[30:0], 1'b1};
    quo_raw   = rq_step[31:0];
    rem_raw   = rq_step[63:32];
    quo_fix   = neg_quo_q ? (~quo_raw + 32'd1) : quo_raw;
    rem_fix   = neg_rem_q ? (~rem_raw + 32'd1) : rem_raw;
    final_res = spec_q ? spec_res_q : (rem_sel_q ? rem_fix : quo_fix);
  end

  // FSM and datapath next-state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rq_d       = rq_q;
    dvsr_d     = dvsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    rem_sel_d  = rem_sel_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      S_IDLE: begin
        result_d = 32'd0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          rq_d       = {33'd0, op1_abs};
          dvsr_d     = op2_abs;
          neg_quo_d  = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          rem_sel_d  = rem_sel_i;
          spec_d     = is_special;
          spec_res_d = spec_val;
          cnt_d      = 5'd0;
`ifdef DIV_SPECIAL_FASTPATH_EN
          if (is_special) begin
            state_d  = S_END;
            result_d = spec_val;
            ready_d  = 1'b1;
          end else begin
            state_d  = S_ON;
          end
`else
          state_d = S_ON;
`endif
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end else begin
          rq_d  = rq_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = S_END;
            result_d = final_res;
            ready_d  = 1'b1;
          end
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_IDLE;
          cnt_d    = 5'd0;
          result_d = 32'd0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = 5'd0;
        result_d = 32'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      rq_q       <= 65'd0;
      dvsr_q     <= 32'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'd0;
      result_q   <= 32'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rq_q       <= rq_d;
      dvsr_q     <= dvsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      rem_sel_q  <= rem_sel_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed checks of ex_div with a result scoreboard.
module tb_ex_div;

`ifdef DIV_SPECIAL_FASTPATH_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        rem_sel_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        annul_i = 1'b0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        ready_prev = 1'b0;

  ex_div dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .rem_sel_i  (rem_sel_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: each rising ready_o must match the oldest expected result
  always @(negedge clk) begin
    if (ready_o === 1'b1 && ready_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got ready with 0x%08h, expected no result", result_o);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
    ready_prev = ready_o;
  end

  // driver: one full request/consume transaction
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic rs, input logic [31:0] exp, input int lat);
    int   cyc;
    logic got;
    logic stall_bad;
    @(posedge clk); #1;
    opdata1_i = a;
    opdata2_i = b;
    signed_i  = sgn;
    rem_sel_i = rs;
    start_i   = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    check("stall_req_cycle", {31'd0, stallreq_o}, 32'd1);
    @(posedge clk); #1;
    // inputs change after the start edge and must be ignored
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_i  = ~sgn;
    rem_sel_i = ~rs;
    cyc = 0;
    got = 1'b0;
    stall_bad = 1'b0;
    while (cyc < 100 && !got) begin
      @(negedge clk);
      cyc++;
      if (ready_o === 1'b1) got = 1'b1;
      else if (stallreq_o !== 1'b1) stall_bad = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got no ready in %0d cycles, expected ready after %0d", cyc, lat);
      void'(exp_q.pop_back());
    end else begin
      check("latency", 32'(cyc), 32'(lat));
      check("stall_before_ready", {31'd0, stall_bad}, 32'd0);
      check("stall_at_ready", {31'd0, stallreq_o}, 32'd0);
      repeat (2) begin
        @(negedge clk);
        check("end_hold_ready", {31'd0, ready_o}, 32'd1);
        check("end_hold_result", result_o, exp);
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, ready_o}, 32'd0);
    check("idle_result", result_o, 32'd0);
  endtask

  // watch ready_o stay low for n cycles
  task automatic watch_quiet(input string name, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    // reset state
    #2;
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // unsigned and signed normal cases
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 33);
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 33);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 33);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 33);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 33);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1, 33);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 33);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 33);

    // special cases
    do_op(32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, SPEC_LAT);
    do_op(32'd5, 32'd0, 1'b0, 1'b1, 32'd5, SPEC_LAT);
    do_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFB, SPEC_LAT);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, SPEC_LAT);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, SPEC_LAT);

    // annul at counter=10
    @(posedge clk); #1;
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; rem_sel_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    check("annul_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    watch_quiet("annul_no_ready", 40);
    do_op(32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 33);

    // annul in IDLE blocks the start
    @(posedge clk); #1;
    opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    check("idle_annul_stall", {31'd0, stallreq_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 start_i = 1'b0; annul_i = 1'b0;
    watch_quiet("idle_annul_no_ready", 40);

    // reset at counter=20
    @(posedge clk); #1;
    opdata1_i = 32'hFFFF_0000; opdata2_i = 32'd3; signed_i = 1'b0; rem_sel_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0; start_i = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 33);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'd0, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
- start_i  input  1  EX requests a divide/remainder; held high until the result is consumed.
- signed_i  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- rem_sel_i  input  1  1 = return remainder, 0 = return quotient.
- opdata1_i  input  32  dividend, taken from the ID/EX register output ex_reg1.
- opdata2_i  input  32  divisor, taken from the ID/EX register output ex_reg2.
- annul_i  input  1  cancels the operation in flight (pipeline flush).
- result_o  output  32  quotient or remainder; valid only while ready_o=1.
- ready_o  output  1  result valid.
- stallreq_o  output  1  combinational stall request to the stall controller, which drives stall[5:0] and freezes ID/EX.

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, ON and END.
REQ-003 In IDLE, if start_i=1 and annul_i=0, the block SHALL sample the operands, signed_i and rem_sel_i on that edge (E0).
- Changes to these inputs after E0 SHALL be ignored until the block returns to IDLE.
REQ-004 A divisor of 0 is a special case. The block SHALL return quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-005 Signed overflow (0x80000000 / 0xFFFFFFFF with signed_i=1) is a special case. The block SHALL return quotient 0x80000000 and remainder 0.
REQ-006 Normal case at E0: the block SHALL go IDLE->ON, load the absolute values of the operands when signed_i=1, and clear a 5-bit iteration counter.
REQ-007 In ON, each edge SHALL perform one restoring radix-2 step using a 65-bit partial-remainder/quotient register and increment the counter.
- The edge with counter=31 SHALL go ON->END and register the final result.
REQ-008 Sign fixup (signed_i=1) SHALL be applied when the result is registered:
- the quotient is negated if the operand signs differ;
- the remainder takes the sign of the dividend.
REQ-009 Normal latency: ready_o SHALL rise in the 33rd cycle after E0, i.e. after 32 ON edges.
REQ-010 In END, ready_o SHALL be 1 and result_o SHALL hold the result.
- END SHALL persist while start_i=1.
- The first edge with start_i=0 SHALL go END->IDLE, clearing ready_o and result_o to 0.
REQ-011 stallreq_o SHALL equal start_i AND NOT ready_o AND NOT annul_i, so EX stalls from the request cycle until the result is present.
REQ-012 annul_i=1 in ON or END SHALL force IDLE on the next edge, with ready_o=0 and no result delivered.
- annul_i=1 in IDLE SHALL block a start on that edge.
REQ-013 annul_i takes priority over start_i when both are asserted on the same edge.
REQ-014 In IDLE, result_o SHALL be 0 and ready_o SHALL be 0.

Reset
REQ-015 rst=0 SHALL immediately set: state=IDLE, counter=0, internal datapath=0, result_o=0, ready_o=0.
REQ-016 Reset asserted mid-operation SHALL abandon the operation.
- After rst returns to 1, a new start SHALL behave exactly as from power-up.

Configuration
REQ-017 With macro DIV_SPECIAL_FASTPATH_EN defined, special cases (REQ-004, REQ-005) SHALL go IDLE->END at E0, so ready_o is 1 in the cycle after E0.
REQ-018 Without DIV_SPECIAL_FASTPATH_EN, special cases SHALL traverse ON for the full 32 edges.
- The special result SHALL be forced on entry to END, giving the same latency as REQ-009.
- Results SHALL be identical with and without the macro; only latency differs.

Verification
REQ-019 Unsigned: 100/7, rem_sel=0 -> result_o=14, ready_o high 33 cycles after E0, stallreq_o high in every cycle before that.
REQ-020 Signed: -7 rem 2, rem_sel=1 -> result_o=0xFFFFFFFF (-1); -7/2 -> 0xFFFFFFFD (-3).
REQ-021 Divide by zero: 5/0 -> quotient 0xFFFFFFFF and remainder 5, after 1 cycle with DIV_SPECIAL_FASTPATH_EN and 33 cycles without.
REQ-022 Overflow: 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0.
REQ-023 Annul at counter=10 -> IDLE next edge, ready_o never asserted, stallreq_o low.
- A following 9/3 start -> result_o=3.
REQ-024 rst pulsed low at counter=20 -> all outputs 0 immediately.
- A start after reset release, 0xFFFFFFFF/1 unsigned -> result_o=0xFFFFFFFF.
